mat_mult_seq: RTL and testbench



---
 rtl/mat_mult_seq.sv | 127 ++++++++++++
 tb/tb_mat_mult_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_seq.sv
// rtl/mat_mult_seq.sv - sequential N x N unsigned matrix multiplier, one MAC per clock
module mat_mult_seq #(
    parameter int N   = 2,
    parameter int DW  = 8,
    parameter int RW  = 17,
    parameter int SAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*N*DW-1:0]   A,
    input  logic [N*N*DW-1:0]   B,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [N*N*RW-1:0]   Res
);
    // Accumulator wide enough that a full dot product of N terms never wraps.
    localparam int AW = 2*DW + $clog2(N);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    logic [N*N*DW-1:0]   r_a;
    logic [N*N*DW-1:0]   r_b;
    logic [IW-1:0]       r_i;
    logic [IW-1:0]       r_j;
    logic [IW-1:0]       r_k;
    logic [AW-1:0]       r_acc;
    logic                r_pend;
    logic [N*N*RW-1:0]   r_buf;

    logic [DW-1:0]       w_a_el;
    logic [DW-1:0]       w_b_el;
    logic [2*DW-1:0]     w_prod;
    logic [AW-1:0]       w_acc_next;
    logic                w_elem_ovf;
    logic [RW-1:0]       w_red;
    logic [N*N*RW-1:0]   w_buf_next;

    // Operand fetch A[i][k], B[k][j] from the latched copies and the MAC sum.
    always_comb begin
        w_a_el     = r_a[(N*N-1-(int'(r_i)*N + int'(r_k)))*DW +: DW];
        w_b_el     = r_b[(N*N-1-(int'(r_k)*N + int'(r_j)))*DW +: DW];
        w_prod     = (2*DW)'(w_a_el) * (2*DW)'(w_b_el);
        w_acc_next = r_acc + AW'(w_prod);
    end

    // Overflow exists only when the result is narrower than the accumulator.
    if (RW < AW) begin : g_trunc
        assign w_elem_ovf = |w_acc_next[AW-1:RW];
    end else begin : g_fit
        assign w_elem_ovf = 1'b0;
    end

    // Reduce the finished dot product to RW bits and merge it into the buffer image.
    always_comb begin
        w_red      = (SAT != 0 && w_elem_ovf) ? {RW{1'b1}} : RW'(w_acc_next);
        w_buf_next = r_buf;
        w_buf_next[(N*N-1-(int'(r_i)*N + int'(r_j)))*RW +: RW] = w_red;
    end

    // Control FSM: latch operands, walk i/j/k row-major, publish result on the final slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_pend  <= 1'b0;
            r_buf   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            Res     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_pend  <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_k != LAST) begin
                        r_k   <= r_k + IW'(1);
                        r_acc <= w_acc_next;
                    end else begin
                        r_k    <= '0;
                        r_acc  <= '0;
                        r_buf  <= w_buf_next;
                        r_pend <= r_pend | w_elem_ovf;
                        if (r_j != LAST) begin
                            r_j <= r_j + IW'(1);
                        end else begin
                            r_j <= '0;
                            if (r_i != LAST) begin
                                r_i <= r_i + IW'(1);
                            end else begin
                                r_i     <= '0;
                                Res     <= w_buf_next;
                                ovf     <= r_pend | w_elem_ovf;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_mult_seq.sv
// tb/tb_mat_mult_seq.sv - directed and random checks of mat_mult_seq against a matrix model
module tb_mat_mult_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1, start3;
    logic [31:0] a0, b0, a1, b1;
    logic [35:0] a3, b3;
    logic        busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2, busy3, done3, ovf3;
    logic [67:0] res0;
    logic [31:0] res1, res2;
    logic [89:0] res3;

    int n_vec  = 0;
    int n_fail = 0;

    mat_mult_seq #(.N(2), .DW(8), .RW(17), .SAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0),
        .busy(busy0), .done(done0), .ovf(ovf0), .Res(res0));
    mat_mult_seq #(.N(2), .DW(8), .RW(8), .SAT(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .ovf(ovf1), .Res(res1));
    mat_mult_seq #(.N(2), .DW(8), .RW(8), .SAT(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .busy(busy2), .done(done2), .ovf(ovf2), .Res(res2));
    mat_mult_seq #(.N(3), .DW(4), .RW(10), .SAT(0)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3),
        .busy(busy3), .done(done3), .ovf(ovf3), .Res(res3));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row-major packing, element 0 in the most significant position.
    function automatic logic [127:0] pack(input int n, input int w, input int v[9]);
        logic [127:0] r;
        r = '0;
        for (int idx = 0; idx < n*n; idx++)
            r |= 128'(v[idx]) << ((n*n-1-idx)*w);
        return r;
    endfunction

    // Plain matrix product with per-element wrap or clamp.
    function automatic logic [127:0] mm_model(input int n, input int rw, input int sat,
                                               input int a[9], input int b[9], output logic ov);
        longint s, lim, v;
        logic [127:0] r;
        r   = '0;
        ov  = 1'b0;
        lim = longint'(1) << rw;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += longint'(a[i*n+k]) * longint'(b[k*n+j]);
                if (s >= lim) begin
                    ov = 1'b1;
                    v  = (sat != 0) ? lim - 1 : s % lim;
                end else begin
                    v = s;
                end
                r |= 128'(v) << ((n*n-1-(i*n+j))*rw);
            end
        end
        return r;
    endfunction

    // Waits for done0 from a known cycle offset; checks busy and Res stability meanwhile.
    task automatic wait_done0(input int lat0, input logic [67:0] prev, output int lat);
        lat = lat0;
        while (done0 !== 1'b1 && lat < 40) begin
            check("busy0_run", 128'(busy0), 128'(1));
            check("res0_hold", 128'(res0), 128'(prev));
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run0(input int a[9], input int b[9]);
        logic [67:0] prev;
        logic        ov;
        int          lat;
        a0 = 32'(pack(2, 8, a));
        b0 = 32'(pack(2, 8, b));
        prev = res0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done0(0, prev, lat);
        check("lat0", 128'(lat), 128'(8));
        check("res0", 128'(res0), mm_model(2, 17, 0, a, b, ov));
        check("ovf0", 128'(ovf0), 128'(ov));
        check("busy0_done", 128'(busy0), 128'(0));
        @(posedge clk); #1;
        check("done0_pulse", 128'(done0), 128'(0));
    endtask

    task automatic run12(input int a[9], input int b[9]);
        logic ov;
        int   lat;
        a1 = 32'(pack(2, 8, a));
        b1 = 32'(pack(2, 8, b));
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lat1", 128'(lat), 128'(8));
        check("done2", 128'(done2), 128'(1));
        check("res1_wrap", 128'(res1), mm_model(2, 8, 0, a, b, ov));
        check("ovf1", 128'(ovf1), 128'(ov));
        check("res2_sat", 128'(res2), mm_model(2, 8, 1, a, b, ov));
        check("ovf2", 128'(ovf2), 128'(ov));
    endtask

    task automatic run3(input int a[9], input int b[9], input bit scramble);
        logic ov;
        int   lat;
        a3 = 36'(pack(3, 4, a));
        b3 = 36'(pack(3, 4, b));
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        if (scramble) begin
            a3 = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
            b3 = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
        end
        lat = 0;
        while (done3 !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lat3", 128'(lat), 128'(27));
        check("res3", 128'(res3), mm_model(3, 10, 0, a, b, ov));
        check("ovf3", 128'(ovf3), 128'(ov));
    endtask

    initial begin
        int          ma[9], mb[9], mc[9], md[9];
        logic [67:0] prev;
        int          lat;
        logic        ov;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a3 = '0; b3 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy0", 128'(busy0), 128'(0));
        check("rst_done0", 128'(done0), 128'(0));
        check("rst_ovf0", 128'(ovf0), 128'(0));
        check("rst_res0", 128'(res0), 128'(0));
        check("rst_res3", 128'(res3), 128'(0));

        // Directed 2x2 product, with an independent constant cross-check.
        ma = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        mb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
        mc = '{19, 22, 43, 50, 0, 0, 0, 0, 0};
        run0(ma, mb);
        check("res0_const", 128'(res0), pack(2, 17, mc));

        // All-ones operands: fits at RW=17, wraps and clamps at RW=8.
        ma = '{255, 255, 255, 255, 0, 0, 0, 0, 0};
        run0(ma, ma);
        mc = '{130050, 130050, 130050, 130050, 0, 0, 0, 0, 0};
        check("res0_max", 128'(res0), pack(2, 17, mc));
        run12(ma, ma);
        check("res1_const", 128'(res1), 128'(32'h02020202));
        check("res2_const", 128'(res2), 128'(32'hFFFFFFFF));
        check("ovf1_const", 128'(ovf1), 128'(1));

        // Abort mid-run with reset.
        ma = '{9, 8, 7, 6, 0, 0, 0, 0, 0};
        a0 = 32'(pack(2, 8, ma));
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy0", 128'(busy0), 128'(0));
        check("abort_done0", 128'(done0), 128'(0));
        check("abort_res0", 128'(res0), 128'(0));
        check("abort_ovf0", 128'(ovf0), 128'(0));
        check("abort_ovf1", 128'(ovf1), 128'(0));
        check("abort_res1", 128'(res1), 128'(0));
        @(posedge clk); #1;
        check("abort_idle0", 128'(busy0), 128'(0));
        for (int t = 0; t < 4; t++) begin ma[t] = $urandom_range(0, 255); mb[t] = $urandom_range(0, 255); end
        run0(ma, mb);

        // Start re-pulsed mid-run is ignored; start during done launches the next run.
        ma = '{3, 1, 4, 1, 0, 0, 0, 0, 0};
        mb = '{5, 9, 2, 6, 0, 0, 0, 0, 0};
        mc = '{200, 100, 50, 25, 0, 0, 0, 0, 0};
        md = '{7, 11, 13, 17, 0, 0, 0, 0, 0};
        a0 = 32'(pack(2, 8, ma));
        b0 = 32'(pack(2, 8, mb));
        prev = res0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        a0 = 32'(pack(2, 8, mc));
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done0(3, prev, lat);
        check("repulse_lat", 128'(lat), 128'(8));
        check("repulse_res", 128'(res0), mm_model(2, 17, 0, ma, mb, ov));
        prev = res0;
        a0 = 32'(pack(2, 8, mc));
        b0 = 32'(pack(2, 8, md));
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        check("b2b_done_low", 128'(done0), 128'(0));
        wait_done0(0, prev, lat);
        check("b2b_lat", 128'(lat), 128'(8));
        check("b2b_res", 128'(res0), mm_model(2, 17, 0, mc, md, ov));
        @(posedge clk); #1;

        // Random 2x2 runs on all three 2x2 configurations.
        for (int r = 0; r < 8; r++) begin
            for (int t = 0; t < 4; t++) begin ma[t] = $urandom_range(0, 255); mb[t] = $urandom_range(0, 255); end
            run0(ma, mb);
            run12(ma, mb);
        end

        // 3x3: identity times 1..9 with inputs disturbed after the latch edge, then random.
        ma = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        mb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run3(ma, mb, 1'b1);
        check("res3_const", 128'(res3), pack(3, 10, mb));
        for (int r = 0; r < 4; r++) begin
            for (int t = 0; t < 9; t++) begin ma[t] = $urandom_range(0, 15); mb[t] = $urandom_range(0, 15); end
            run3(ma, mb, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
